gray_counter: RTL and testbench

- Parametrised, registered Gray-code counter with up/down count, parallel load, and a wrap indication.
- Also contains an independent one-cycle pipelined Gray-to-binary conversion channel.
- Successor to the fixed 4-bit combinational binary-to-Gray converter.
- Used for pointer generation and position encoding in the Binary Codes block set.

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray_to_bin_stage.sv | 40 ++++
 rtl/gray_counter.sv | 102 ++++++++++
 tb/tb_gray_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and Gray/binary helpers for the gray_counter block set.
// Helpers work on a wide word so any WIDTH below GRAY_MAX_WIDTH can use them.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH     = 64;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_LOAD,
    CNT_UP,
    CNT_DOWN
  } cnt_op_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs keep the upper prefix at 0, so the low WIDTH bits are exact.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t r;
    r[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_to_bin_stage.sv
// One-cycle registered Gray-to-binary conversion channel (valid + data register).
// Data holds its last value whenever no request is presented.
module gray_to_bin_stage
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_gray,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_bin
);

  logic                            valid_reg;
  logic [WIDTH-1:0]                bin_reg;
  logic [WIDTH-1:0]                bin_next;
  logic [GRAY_MAX_WIDTH-WIDTH-1:0] unused_bin_hi;

  always_comb begin
    {unused_bin_hi, bin_next} = gray2bin(gray_word_t'(req_gray));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      bin_reg   <= '0;
    end else begin
      valid_reg <= req_valid;
      if (req_valid) begin
        bin_reg <= bin_next;
      end
    end
  end

  assign res_valid = valid_reg;
  assign res_bin   = bin_reg;

endmodule

// File: rtl/gray_counter.sv
// Registered Gray-code up/down counter with parallel load and wrap pulse, plus an
// independent conversion channel. Define GRAY_CNT_SAT_EN to saturate instead of wrapping.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap,
  input  logic             conv_valid_in,
  input  logic [WIDTH-1:0] conv_gray_in,
  output logic             conv_valid_out,
  output logic [WIDTH-1:0] conv_bin_out
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  cnt_op_t                         op;
  logic [WIDTH-1:0]                bin_reg, bin_next;
  logic [WIDTH-1:0]                gray_reg, gray_next;
  logic                            wrap_reg, wrap_next;
  logic [GRAY_MAX_WIDTH-WIDTH-1:0] unused_gray_hi;

  always_comb begin
    op = CNT_HOLD;
    if (load) begin
      op = CNT_LOAD;
    end else if (en) begin
      op = up ? CNT_UP : CNT_DOWN;
    end
  end

  // Gray is derived from the next binary value so both registers update together.
  always_comb begin
    bin_next  = bin_reg;
    wrap_next = 1'b0;
    case (op)
      CNT_LOAD: bin_next = load_bin;
      CNT_UP: begin
        if (bin_reg == ALL_ONES) begin
          wrap_next = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          bin_next = bin_reg;
`else
          bin_next = '0;
`endif
        end else begin
          bin_next = bin_reg + WIDTH'(1);
        end
      end
      CNT_DOWN: begin
        if (bin_reg == '0) begin
          wrap_next = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          bin_next = bin_reg;
`else
          bin_next = ALL_ONES;
`endif
        end else begin
          bin_next = bin_reg - WIDTH'(1);
        end
      end
      default: bin_next = bin_reg;
    endcase
    {unused_gray_hi, gray_next} = bin2gray(gray_word_t'(bin_next));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      wrap_reg <= wrap_next;
    end
  end

  assign bin  = bin_reg;
  assign gray = gray_reg;
  assign wrap = wrap_reg;

  gray_to_bin_stage #(
    .WIDTH(WIDTH)
  ) u_conv (
    .clk      (clk),
    .reset    (reset),
    .req_valid(conv_valid_in),
    .req_gray (conv_gray_in),
    .res_valid(conv_valid_out),
    .res_bin  (conv_bin_out)
  );

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: directed vector table, hand-written wrap sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_gray_counter;

  localparam int W   = 4;
  localparam int LIM = 1 << W;

  logic         clk = 1'b0;
  logic         reset, en, up, load, conv_valid_in;
  logic [W-1:0] load_bin, conv_gray_in;
  logic [W-1:0] gray, bin, conv_bin_out;
  logic         wrap, conv_valid_out;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_bin = 0, m_wrap = 0, m_cv = 0, m_cb = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .up            (up),
    .load          (load),
    .load_bin      (load_bin),
    .gray          (gray),
    .bin           (bin),
    .wrap          (wrap),
    .conv_valid_in (conv_valid_in),
    .conv_gray_in  (conv_gray_in),
    .conv_valid_out(conv_valid_out),
    .conv_bin_out  (conv_bin_out)
  );

  typedef struct {
    logic         r, e, u, l;
    logic [W-1:0] lb;
    logic         cv;
    logic [W-1:0] cg;
    logic [W-1:0] x_bin, x_gray;
    logic         x_wrap, x_cv;
    logic [W-1:0] x_cb;
  } vec_t;

  vec_t tbl[14];

  // Binary whose Gray code is g, found by exhaustive search.
  function automatic int g2b(input int g);
    for (int b = 0; b < LIM; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_bin = 0; m_wrap = 0; m_cv = 0; m_cb = 0;
    end else begin
      m_cv = int'(conv_valid_in);
      if (conv_valid_in) m_cb = g2b(int'(conv_gray_in));
      m_wrap = 0;
      if (load) begin
        m_bin = int'(load_bin);
      end else if (en) begin
        if ((up && m_bin == LIM - 1) || (!up && m_bin == 0)) begin
          m_wrap = 1;
`ifdef GRAY_CNT_SAT_EN
          m_bin = m_bin;
`else
          m_bin = up ? 0 : LIM - 1;
`endif
        end else begin
          m_bin = up ? m_bin + 1 : m_bin - 1;
        end
      end
    end
  endtask

  task automatic apply(input logic r, e, u, l, input logic [W-1:0] lb,
                       input logic cvi, input logic [W-1:0] cgi);
    reset = r; en = e; up = u; load = l; load_bin = lb;
    conv_valid_in = cvi; conv_gray_in = cgi;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".bin"},  32'(bin),            32'(m_bin));
    check({tag, ".gray"}, 32'(gray),           32'(gray_of(m_bin)));
    check({tag, ".wrap"}, 32'(wrap),           32'(m_wrap));
    check({tag, ".cv"},   32'(conv_valid_out), 32'(m_cv));
    check({tag, ".cb"},   32'(conv_bin_out),   32'(m_cb));
  endtask

  logic [W-1:0] prev_gray, prev_bin;

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
    conv_valid_in = 1'b0; conv_gray_in = '0;

    // r e u l lb cv cg | bin gray wrap cv cb
    tbl[0]  = '{1,1,1,1,4'hA,1,4'h8, 4'h0,4'h0,0,0,4'h0};
    tbl[1]  = '{1,1,1,1,4'hA,1,4'h8, 4'h0,4'h0,0,0,4'h0};
    tbl[2]  = '{0,1,0,1,4'hF,0,4'h0, 4'hF,4'h8,0,0,4'h0};
    tbl[3]  = '{0,1,1,1,4'h0,0,4'h0, 4'h0,4'h0,0,0,4'h0};
`ifdef GRAY_CNT_SAT_EN
    tbl[4]  = '{0,1,0,0,4'h0,0,4'h0, 4'h0,4'h0,1,0,4'h0};
`else
    tbl[4]  = '{0,1,0,0,4'h0,0,4'h0, 4'hF,4'h8,1,0,4'h0};
`endif
    tbl[5]  = '{0,1,1,1,4'h5,1,4'h8, 4'h5,4'h7,0,1,4'hF};
    tbl[6]  = '{0,0,1,0,4'h0,1,4'h3, 4'h5,4'h7,0,1,4'h2};
    tbl[7]  = '{0,0,1,0,4'h0,1,4'h6, 4'h5,4'h7,0,1,4'h4};
    tbl[8]  = '{0,0,1,0,4'h0,0,4'h9, 4'h5,4'h7,0,0,4'h4};
    tbl[9]  = '{1,1,1,1,4'hC,1,4'h1, 4'h0,4'h0,0,0,4'h0};
    tbl[10] = '{0,0,0,1,4'h7,0,4'h0, 4'h7,4'h4,0,0,4'h0};
    tbl[11] = '{0,0,1,0,4'h3,0,4'h0, 4'h7,4'h4,0,0,4'h0};
    tbl[12] = '{0,0,0,0,4'h9,0,4'h0, 4'h7,4'h4,0,0,4'h0};
    tbl[13] = '{0,0,1,0,4'h1,0,4'h0, 4'h7,4'h4,0,0,4'h0};

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lb, tbl[i].cv, tbl[i].cg);
      check($sformatf("vec%0d.bin", i),  32'(bin),            32'(tbl[i].x_bin));
      check($sformatf("vec%0d.gray", i), 32'(gray),           32'(tbl[i].x_gray));
      check($sformatf("vec%0d.wrap", i), 32'(wrap),           32'(tbl[i].x_wrap));
      check($sformatf("vec%0d.cv", i),   32'(conv_valid_out), 32'(tbl[i].x_cv));
      check($sformatf("vec%0d.cb", i),   32'(conv_bin_out),   32'(tbl[i].x_cb));
      $display("vec %0d: bin=%h gray=%h wrap=%b cv=%b cb=%h", i, bin, gray, wrap,
               conv_valid_out, conv_bin_out);
    end

    // Count up from 0 through the top and past it.
    apply(1, 0, 0, 0, '0, 0, '0);
    for (int s = 1; s <= 17; s++) begin
      prev_gray = gray;
      prev_bin  = bin;
      apply(0, 1, 1, 0, '0, 0, '0);
      check_model($sformatf("up%0d", s));
      if (bin != prev_bin)
        check($sformatf("up%0d.onebit", s), 32'($countones(gray ^ prev_gray)), 32'd1);
      if (s == 15) begin
        check("up15.gray_top", 32'(gray), 32'h8);
        check("up15.no_wrap",  32'(wrap), 32'd0);
      end
`ifndef GRAY_CNT_SAT_EN
      if (s == 16) check("up16.rollover", 32'({wrap, bin, gray}), 32'h100);
      if (s == 17) check("up17.wrap_drop", 32'(wrap), 32'd0);
`endif
      $display("up %0d: bin=%h gray=%h wrap=%b", s, bin, gray, wrap);
    end

`ifdef GRAY_CNT_SAT_EN
    apply(0, 0, 0, 1, 4'hF, 0, '0);
    for (int s = 0; s < 3; s++) begin
      apply(0, 1, 1, 0, '0, 0, '0);
      check($sformatf("sat_hi%0d", s), 32'({wrap, bin, gray}), 32'h1F8);
      $display("sat_hi %0d: bin=%h gray=%h wrap=%b", s, bin, gray, wrap);
    end
    apply(0, 0, 0, 1, 4'h0, 0, '0);
    apply(0, 1, 0, 0, '0, 0, '0);
    check("sat_lo", 32'({wrap, bin, gray}), 32'h100);
    $display("sat_lo: bin=%h gray=%h wrap=%b", bin, gray, wrap);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic r, e, u, l, cvi;
      logic [W-1:0] lb, cgi;
      r   = ($urandom_range(0, 31) == 0);
      l   = ($urandom_range(0, 7) == 0);
      e   = ($urandom_range(0, 3) != 0);
      u   = 1'($urandom_range(0, 1));
      cvi = 1'($urandom_range(0, 1));
      lb  = W'($urandom);
      cgi = W'($urandom);
      prev_gray = gray;
      prev_bin  = bin;
      apply(r, e, u, l, lb, cvi, cgi);
      check_model($sformatf("rnd%0d", n));
      if (!r && !l && e && bin != prev_bin)
        check($sformatf("rnd%0d.onebit", n), 32'($countones(gray ^ prev_gray)), 32'd1);
      $display("rnd %0d: r=%b l=%b e=%b u=%b -> bin=%h gray=%h wrap=%b cv=%b cb=%h",
               n, r, l, e, u, bin, gray, wrap, conv_valid_out, conv_bin_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
